ariane_axi_id_remap: RTL
========================

// Module: ariane_axi_id_remap
// PURPOSE
// - Downstream neighbour of the SoC AXI crossbar slave port: accepts ariane_axi::req_slv_t/resp_slv_t
//   (id_slv_t IDs) and drives ariane_axi::req_t/resp_t toward the memory-side master port.
// - Compresses the sparse crossbar ID space onto NumSlots dense IDs via outstanding-transaction tables.
// - Restores the original ID on B/R and preserves AXI same-ID ordering.
// PARAMETERS
// - NumSlots      default 4  remap table entries per direction; requires NumSlots <= 2**ariane_soc::IdWidth
// - MaxTxnsPerId  default 4  max outstanding transactions per slot (counter saturation bound)
// PORTS
// - clk_i   in   1                        clock
// - rst_ni  in   1                        asynchronous active-low reset
// - slv_req_i   in   $bits(req_slv_t)     upstream request (id_slv_t IDs)
// - slv_resp_o  out  $bits(resp_slv_t)    upstream response, original IDs restored
// - mst_req_o   out  $bits(req_t)         downstream request, id = zero-extended slot index, user = '0
// - mst_resp_i  in   $bits(resp_t)        downstream response; b.id/r.id must be < NumSlots
// BEHAVIOUR
// - Interface fixed: single clock clk_i; reset rst_ni is asynchronous, active-low.
// - Two independent tables (write: AW/B, read: AR/R); entry = {valid, orig_id, cnt[$clog2(MaxTxnsPerId+1)-1:0]}.
// - Reset: all entries invalid, cnt=0. Outputs after reset: all valid/ready low except combinational
//   pass-through of mst ready/valid gated by table state; no registered outputs.
// - Slot select on AW (AR analogous): if a valid entry holds orig_id==aw.id: use it if cnt<MaxTxnsPerId,
//   else stall (never open a second slot for one ID, to keep same-ID ordering). No match: lowest-index
//   invalid entry. No match and table full: stall.
// - Handshake (zero latency, combinational): mst aw_valid = slv aw_valid & avail; slv aw_ready = mst aw_ready & avail.
//   avail never depends on any ready. All other AW/AR fields forwarded unchanged; W forwarded unchanged.
// - ATOP with atop[5]=1 (read response expected): needs avail in both tables using aw.id; on handshake both
//   tables allocate/increment; the read-side slot index must equal the write-side index, else stall.
// - On mst AW/AR handshake: entry valid<=1, orig_id<=id, cnt<=cnt+1 (registered, visible next cycle).
// - B: slv b.id = wtab[mst b.id].orig_id; on slv B handshake cnt-1. R: id restored likewise; cnt-1 only on r.last handshake.
// - Entry invalidated when cnt reaches 0. Same-cycle +1 and -1 on one slot: cnt unchanged, entry stays valid.
// - Same-cycle allocate of slot k and final release of slot k is impossible (allocation only targets invalid
//   or matching entries); release of k plus allocate of another ID on a different slot both occur.
// - Reset mid-operation: tables cleared immediately; in-flight transactions are lost (global reset only).
// - Assertions: response ID >= NumSlots, response on invalid entry, cnt underflow/overflow -> $error.
// STRUCTURE
// - Sub-module ariane_axi_id_remap_table (instantiated twice): lookup/allocate by orig_id, push/pop by slot,
//   outputs avail, slot_idx, orig_id_of_slot; ~120 lines.
// - No new shared typedefs: reuse ariane_axi req_slv_t/resp_slv_t/req_t/resp_t and id_slv_t/id_t;
//   slot index typedef and cnt width are local parameters of the table.
// TESTING
// - Single write aw.id=5 after reset -> mst aw.id=0, cnt[0]=1; mst b.id=0 -> slv b.id=5, slot 0 freed next cycle.
// - Four reads ids 3,7,9,12 with NumSlots=4 -> mst ids 0..3; fifth AR id=14 -> ar_ready low until any r.last retires.
// - Five ARs id=3 with MaxTxnsPerId=4 -> all on slot 0, fifth stalls; one r.last (r.id=0) -> fifth accepted next cycle.
// - Burst read len=3 on id=2 -> slot counter decrements only on beat with r.last=1; beats 0-2 keep slot held.
// - Same cycle: new AW id=6 and final B for slot 1 (id=4) -> AW takes slot 0 (lowest free), slot 1 freed, no glitch.
// - ATOP atop=6'b100000 id=8 -> both tables allocate slot 0; B and R both return orig id 8; reset mid-burst -> all slots free.

Source files
------------

// File: rtl/ariane_axi_id_remap_pkg.sv
// rtl/ariane_axi_id_remap_pkg.sv - AXI channel types seen on both sides of the ID remapper
package ariane_axi_id_remap_pkg;
  // Slave side carries the wider crossbar IDs; master side carries the dense memory-side IDs.
  localparam int unsigned IdWidth    = 4;
  localparam int unsigned IdWidthSlv = 5;
  localparam int unsigned AddrWidth  = 64;
  localparam int unsigned DataWidth  = 64;

  typedef logic [IdWidth-1:0]       id_t;
  typedef logic [IdWidthSlv-1:0]    id_slv_t;
  typedef logic [AddrWidth-1:0]     addr_t;
  typedef logic [DataWidth-1:0]     data_t;
  typedef logic [DataWidth/8-1:0]   strb_t;

  typedef struct packed {
    id_t id; addr_t addr; logic [7:0] len; logic [2:0] size; logic [1:0] burst; logic [5:0] atop; logic user;
  } aw_chan_t;
  typedef struct packed {
    id_slv_t id; addr_t addr; logic [7:0] len; logic [2:0] size; logic [1:0] burst; logic [5:0] atop; logic user;
  } aw_chan_slv_t;
  typedef struct packed {
    id_t id; addr_t addr; logic [7:0] len; logic [2:0] size; logic [1:0] burst; logic user;
  } ar_chan_t;
  typedef struct packed {
    id_slv_t id; addr_t addr; logic [7:0] len; logic [2:0] size; logic [1:0] burst; logic user;
  } ar_chan_slv_t;
  typedef struct packed { data_t data; strb_t strb; logic last; logic user; } w_chan_t;
  typedef struct packed { id_t id; logic [1:0] resp; logic user; } b_chan_t;
  typedef struct packed { id_slv_t id; logic [1:0] resp; logic user; } b_chan_slv_t;
  typedef struct packed { id_t id; data_t data; logic [1:0] resp; logic last; logic user; } r_chan_t;
  typedef struct packed { id_slv_t id; data_t data; logic [1:0] resp; logic last; logic user; } r_chan_slv_t;

  typedef struct packed {
    aw_chan_t aw; logic aw_valid; w_chan_t w; logic w_valid; logic b_ready;
    ar_chan_t ar; logic ar_valid; logic r_ready;
  } req_t;
  typedef struct packed {
    logic aw_ready; logic ar_ready; logic w_ready; logic b_valid; b_chan_t b; logic r_valid; r_chan_t r;
  } resp_t;
  typedef struct packed {
    aw_chan_slv_t aw; logic aw_valid; w_chan_t w; logic w_valid; logic b_ready;
    ar_chan_slv_t ar; logic ar_valid; logic r_ready;
  } req_slv_t;
  typedef struct packed {
    logic aw_ready; logic ar_ready; logic w_ready; logic b_valid; b_chan_slv_t b; logic r_valid; r_chan_slv_t r;
  } resp_slv_t;
endpackage

// File: rtl/ariane_axi_id_remap_table.sv
// rtl/ariane_axi_id_remap_table.sv - outstanding-transaction table mapping original IDs to dense slots
module ariane_axi_id_remap_table #(
  parameter int unsigned NumSlots     = 4,
  parameter int unsigned MaxTxnsPerId = 4,
  parameter int unsigned OrigIdWidth  = 5,
  localparam int unsigned SlotWidth   = (NumSlots > 1) ? $clog2(NumSlots) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [OrigIdWidth-1:0] lookup_id,
  output logic                   avail,
  output logic [SlotWidth-1:0]   slot_idx,
  input  logic                   push,
  input  logic                   pop,
  input  logic [SlotWidth-1:0]   pop_slot,
  output logic [OrigIdWidth-1:0] orig_id_of_slot,
  output logic                   pop_slot_valid
);
  localparam int unsigned CntWidth = $clog2(MaxTxnsPerId + 1);

  typedef logic [SlotWidth-1:0] slot_t;
  typedef logic [CntWidth-1:0]  cnt_t;

  localparam cnt_t CntMax = cnt_t'(MaxTxnsPerId);

  logic [NumSlots-1:0]    valid_q;
  logic [OrigIdWidth-1:0] orig_q [NumSlots];
  cnt_t                   cnt_q  [NumSlots];
  logic                   match_hit, free_hit;
  slot_t                  match_idx, free_idx;
  logic [NumSlots-1:0]    inc, dec;

  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    free_hit  = 1'b0;
    free_idx  = '0;
    for (int unsigned i = 0; i < NumSlots; i++) begin
      if (valid_q[i] && (orig_q[i] == lookup_id) && !match_hit) begin
        match_hit = 1'b1;
        match_idx = slot_t'(i);
      end
      if (!valid_q[i] && !free_hit) begin
        free_hit = 1'b1;
        free_idx = slot_t'(i);
      end
    end
  end

  // An ID that owns a slot must stay on it even when saturated, otherwise same-ID ordering breaks.
  assign avail           = match_hit ? (cnt_q[match_idx] < CntMax) : free_hit;
  assign slot_idx        = match_hit ? match_idx : free_idx;
  assign orig_id_of_slot = orig_q[pop_slot];
  assign pop_slot_valid  = valid_q[pop_slot];

  always_comb begin
    inc = '0;
    dec = '0;
    for (int unsigned i = 0; i < NumSlots; i++) begin
      inc[i] = push && (slot_idx == slot_t'(i));
      dec[i] = pop && (pop_slot == slot_t'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < NumSlots; i++) begin
        orig_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NumSlots; i++) begin
        if (inc[i] && !dec[i]) begin
          valid_q[i] <= 1'b1;
          orig_q[i]  <= lookup_id;
          cnt_q[i]   <= cnt_q[i] + 1'b1;
        end else if (dec[i] && !inc[i]) begin
          cnt_q[i] <= cnt_q[i] - 1'b1;
          if (cnt_q[i] == cnt_t'(1)) valid_q[i] <= 1'b0;
        end
      end
    end
  end

  assert property (@(posedge clk) disable iff (!rst_n) pop |-> (cnt_q[pop_slot] != '0))
    else $error("id remap table: counter underflow on slot %0d", pop_slot);
  assert property (@(posedge clk) disable iff (!rst_n) push |-> avail)
    else $error("id remap table: counter overflow on allocation");
endmodule

// File: rtl/ariane_axi_id_remap.sv
// rtl/ariane_axi_id_remap.sv - compresses crossbar AXI IDs onto NumSlots dense IDs and restores them on B/R
module ariane_axi_id_remap
  import ariane_axi_id_remap_pkg::*;
#(
  parameter int unsigned NumSlots     = 4,
  parameter int unsigned MaxTxnsPerId = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [$bits(req_slv_t)-1:0]   slv_req_i,
  output logic [$bits(resp_slv_t)-1:0]  slv_resp_o,
  output logic [$bits(req_t)-1:0]       mst_req_o,
  input  logic [$bits(resp_t)-1:0]      mst_resp_i
);
  localparam int unsigned SlotWidth = (NumSlots > 1) ? $clog2(NumSlots) : 1;

  req_slv_t  slv_req;
  resp_slv_t slv_resp;
  req_t      mst_req;
  resp_t     mst_resp;

  assign slv_req    = slv_req_i;
  assign mst_resp   = mst_resp_i;
  assign slv_resp_o = slv_resp;
  assign mst_req_o  = mst_req;

  logic                 wtab_avail, rtab_avail, wtab_pop_valid, rtab_pop_valid;
  logic [SlotWidth-1:0] wtab_slot, rtab_slot;
  id_slv_t              wtab_orig, rtab_orig, rtab_lookup;
  logic                 atop_rd, aw_avail, ar_avail, aw_hs, ar_hs, wtab_pop, rtab_pop;

  // Atomics that return read data claim the read table on behalf of AW, so AR yields that cycle.
  assign atop_rd     = slv_req.aw_valid && slv_req.aw.atop[5];
  assign rtab_lookup = atop_rd ? slv_req.aw.id : slv_req.ar.id;
  assign aw_avail    = wtab_avail && (!atop_rd || (rtab_avail && (rtab_slot == wtab_slot)));
  assign ar_avail    = rtab_avail && !atop_rd;
  assign aw_hs       = slv_req.aw_valid && aw_avail && mst_resp.aw_ready;
  assign ar_hs       = slv_req.ar_valid && ar_avail && mst_resp.ar_ready;
  assign wtab_pop    = mst_resp.b_valid && slv_req.b_ready;
  assign rtab_pop    = mst_resp.r_valid && slv_req.r_ready && mst_resp.r.last;

  ariane_axi_id_remap_table #(
    .NumSlots(NumSlots), .MaxTxnsPerId(MaxTxnsPerId), .OrigIdWidth(IdWidthSlv)
  ) i_wtab (
    .clk(clk_i), .rst_n(rst_ni), .lookup_id(slv_req.aw.id), .avail(wtab_avail), .slot_idx(wtab_slot),
    .push(aw_hs), .pop(wtab_pop), .pop_slot(mst_resp.b.id[SlotWidth-1:0]),
    .orig_id_of_slot(wtab_orig), .pop_slot_valid(wtab_pop_valid)
  );

  ariane_axi_id_remap_table #(
    .NumSlots(NumSlots), .MaxTxnsPerId(MaxTxnsPerId), .OrigIdWidth(IdWidthSlv)
  ) i_rtab (
    .clk(clk_i), .rst_n(rst_ni), .lookup_id(rtab_lookup), .avail(rtab_avail), .slot_idx(rtab_slot),
    .push(ar_hs || (atop_rd && aw_hs)), .pop(rtab_pop), .pop_slot(mst_resp.r.id[SlotWidth-1:0]),
    .orig_id_of_slot(rtab_orig), .pop_slot_valid(rtab_pop_valid)
  );

  always_comb begin
    mst_req          = '0;
    mst_req.aw.id    = IdWidth'(wtab_slot);
    mst_req.aw.addr  = slv_req.aw.addr;
    mst_req.aw.len   = slv_req.aw.len;
    mst_req.aw.size  = slv_req.aw.size;
    mst_req.aw.burst = slv_req.aw.burst;
    mst_req.aw.atop  = slv_req.aw.atop;
    mst_req.aw_valid = slv_req.aw_valid && aw_avail;
    mst_req.w        = slv_req.w;
    mst_req.w_valid  = slv_req.w_valid;
    mst_req.b_ready  = slv_req.b_ready;
    mst_req.ar.id    = IdWidth'(rtab_slot);
    mst_req.ar.addr  = slv_req.ar.addr;
    mst_req.ar.len   = slv_req.ar.len;
    mst_req.ar.size  = slv_req.ar.size;
    mst_req.ar.burst = slv_req.ar.burst;
    mst_req.ar_valid = slv_req.ar_valid && ar_avail;
    mst_req.r_ready  = slv_req.r_ready;
  end

  always_comb begin
    slv_resp          = '0;
    slv_resp.aw_ready = mst_resp.aw_ready && aw_avail;
    slv_resp.ar_ready = mst_resp.ar_ready && ar_avail;
    slv_resp.w_ready  = mst_resp.w_ready;
    slv_resp.b_valid  = mst_resp.b_valid;
    slv_resp.b.id     = wtab_orig;
    slv_resp.b.resp   = mst_resp.b.resp;
    slv_resp.b.user   = mst_resp.b.user;
    slv_resp.r_valid  = mst_resp.r_valid;
    slv_resp.r.id     = rtab_orig;
    slv_resp.r.data   = mst_resp.r.data;
    slv_resp.r.resp   = mst_resp.r.resp;
    slv_resp.r.last   = mst_resp.r.last;
    slv_resp.r.user   = mst_resp.r.user;
  end

  assert property (@(posedge clk_i) disable iff (!rst_ni)
    mst_resp.b_valid |-> (32'(mst_resp.b.id) < NumSlots) && wtab_pop_valid)
    else $error("id remap: B response id %0d out of range or on idle slot", mst_resp.b.id);
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    mst_resp.r_valid |-> (32'(mst_resp.r.id) < NumSlots) && rtab_pop_valid)
    else $error("id remap: R response id %0d out of range or on idle slot", mst_resp.r.id);
endmodule
